// File: rtl/hms_edit_timer.sv
// rtl/hms_edit_timer.sv - hours/minutes/seconds timekeeper with button front end and edit mode
//
// Purpose: keeps hh:mm:ss time, advanced by a TICK_DIV prescaler while
// running. Four level buttons are arbitrated (ss > sel > inc > dec) and
// edge-detected internally. An edit mode allows field select, stepping with
// hold-to-repeat, and leaves on its own after TIMEOUT_CYC idle cycles. A
// direct load port writes any field with saturation.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   ss/sel/inc/dec  debounced button levels
//   load/addr/din   direct field write (addr 00 sec, 01 min, 10 hrs, 11 none)
//   hrs/min/sec     current time (registered)
//   running         high in RUN
//   edit_field      00 none, 01 sec, 10 min, 11 hrs
//   timeout_evt     one-cycle pulse when edit mode times out
module hms_edit_timer #(
  parameter int TICK_DIV    = 50000000,
  parameter int HR_MAX      = 23,
  parameter int TIMEOUT_CYC = 500000000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] addr,
  input  logic [5:0] din,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic [1:0] edit_field,
  output logic       timeout_evt
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] RPT_DLY   = 32'(REPEAT_DLY);
  localparam logic [31:0] RPT_RATE  = 32'(REPEAT_RATE);
  localparam logic [4:0]  HR_TOP    = 5'(HR_MAX);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_EDIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  hrs_q, hrs_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [1:0]  field_q, field_d;
  logic        evt_q, evt_d;
  logic [31:0] pre_q, pre_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] rep_q, rep_d;
  logic        rpt_q, rpt_d;   // 0: waiting out REPEAT_DLY, 1: stepping at REPEAT_RATE
  logic [3:0]  prev_q, prev_d; // arbitrated vector from last cycle {ss,sel,inc,dec}
  logic        first_q, first_d; // first cycle after reset: swallow edges of held buttons

  logic [3:0]  arb;
  logic [3:0]  act;
  logic        tick;
  logic        do_step;
  logic        step_up;

  always_comb begin
    arb = 4'b0000;
    if (ss)       arb = 4'b1000;
    else if (sel) arb = 4'b0100;
    else if (inc) arb = 4'b0010;
    else if (dec) arb = 4'b0001;

    // Edges in a load cycle are discarded; load always wins.
    act = (first_q || load) ? 4'b0000 : (arb & ~prev_q);

    prev_d   = arb;
    first_d  = 1'b0;
    state_d  = state_q;
    field_d  = field_q;
    hrs_d    = hrs_q;
    min_d    = min_q;
    sec_d    = sec_q;
    evt_d    = 1'b0;
    pre_d    = 32'd0;
    idle_d   = 32'd0;
    rep_d    = 32'd0;
    rpt_d    = 1'b0;
    tick     = 1'b0;
    do_step  = 1'b0;
    step_up  = arb[1];

    case (state_q)
      ST_RUN: begin
        tick  = (pre_q == TICK_LAST);
        pre_d = tick ? 32'd0 : pre_q + 32'd1;
        if (act[3]) begin
          state_d = ST_STOP;
        end else if (act[2]) begin
          state_d = ST_EDIT;
          field_d = 2'b01;
        end
      end
      ST_STOP: begin
        if (act[3]) begin
          state_d = ST_RUN;
        end else if (act[2]) begin
          state_d = ST_EDIT;
          field_d = 2'b01;
        end
      end
      ST_EDIT: begin
        if (act[3]) begin
          state_d = ST_RUN;
          field_d = 2'b00;
        end else if (act[2]) begin
          field_d = (field_q == 2'b11) ? 2'b01 : field_q + 2'b01;
        end else if (arb[1] || arb[0]) begin
          if (act[1] || act[0]) begin
            do_step = 1'b1;
            rep_d   = 32'd1;
          end else if ((!rpt_q && rep_q == RPT_DLY) || (rpt_q && rep_q == RPT_RATE)) begin
            do_step = !load;
            rep_d   = 32'd1;
            rpt_d   = 1'b1;
          end else begin
            rep_d = rep_q + 32'd1;
            rpt_d = rpt_q;
          end
        end

        if (arb == 4'b0000 && !load) begin
          if (idle_q == IDLE_LAST) begin
            state_d = ST_STOP;
            field_d = 2'b00;
            evt_d   = 1'b1;
          end else begin
            idle_d = idle_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
        field_d = 2'b00;
      end
    endcase

    if (state_d != ST_RUN) pre_d = 32'd0;

    // A tick in a load cycle is dropped for every field, not only the loaded one.
    if (tick && !load) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hrs_d = (hrs_q >= HR_TOP) ? 5'd0 : hrs_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Edit steps wrap within the field; no carry between fields.
    if (do_step) begin
      case (field_q)
        2'b01: sec_d = step_up ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                               : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
        2'b10: min_d = step_up ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                               : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
        2'b11: hrs_d = step_up ? ((hrs_q >= HR_TOP) ? 5'd0 : hrs_q + 5'd1)
                               : ((hrs_q == 5'd0) ? HR_TOP : hrs_q - 5'd1);
        default: ;
      endcase
    end

    if (load) begin
      case (addr)
        2'b00: sec_d = (din > 6'd59) ? 6'd59 : din;
        2'b01: min_d = (din > 6'd59) ? 6'd59 : din;
        2'b10: hrs_d = (din[4:0] > HR_TOP) ? HR_TOP : din[4:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_STOP;
      field_q <= 2'b00;
      hrs_q   <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      evt_q   <= 1'b0;
      pre_q   <= 32'd0;
      idle_q  <= 32'd0;
      rep_q   <= 32'd0;
      rpt_q   <= 1'b0;
      prev_q  <= 4'b0000;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      evt_q   <= evt_d;
      pre_q   <= pre_d;
      idle_q  <= idle_d;
      rep_q   <= rep_d;
      rpt_q   <= rpt_d;
      prev_q  <= prev_d;
      first_q <= first_d;
    end
  end

  assign hrs         = hrs_q;
  assign min         = min_q;
  assign sec         = sec_q;
  assign running     = (state_q == ST_RUN);
  assign edit_field  = field_q;
  assign timeout_evt = evt_q;

endmodule

// File: tb/tb_hms_edit_timer.sv
// tb/tb_hms_edit_timer.sv - directed self-checking bench for hms_edit_timer
module tb_hms_edit_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss, sel, inc, dec;
  logic       load;
  logic [1:0] addr;
  logic [5:0] din;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic [1:0] edit_field;
  logic       timeout_evt;

  int n_checks = 0;
  int n_fail   = 0;
  int evt_cnt  = 0;

  hms_edit_timer #(
    .TICK_DIV(4), .HR_MAX(23), .TIMEOUT_CYC(20), .REPEAT_DLY(8), .REPEAT_RATE(2)
  ) dut (
    .clk(clk), .rst(rst), .ss(ss), .sel(sel), .inc(inc), .dec(dec),
    .load(load), .addr(addr), .din(din),
    .hrs(hrs), .min(min), .sec(sec), .running(running),
    .edit_field(edit_field), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && timeout_evt) evt_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b);
    {ss, sel, inc, dec} = b;
    step(1);
    {ss, sel, inc, dec} = 4'b0000;
    step(1);
  endtask

  task automatic do_load(input logic [1:0] a, input logic [5:0] d);
    load = 1'b1; addr = a; din = d;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; {ss, sel, inc, dec} = 4'b0000; load = 1'b0; addr = 2'b00; din = 6'd0;
    step(3);
    check("rst_hrs", 32'(hrs), 0);
    check("rst_min", 32'(min), 0);
    check("rst_sec", 32'(sec), 0);
    check("rst_running", 32'(running), 0);
    check("rst_field", 32'(edit_field), 0);
    check("rst_evt", 32'(timeout_evt), 0);
    rst = 1'b1;
    step(2);

    // start, first tick four cycles after entering RUN, minute rollover after 240
    ss = 1'b1; step(1); ss = 1'b0;
    check("run_on", 32'(running), 1);
    step(3);
    check("tick_early_sec", 32'(sec), 0);
    step(1);
    check("tick_first_sec", 32'(sec), 1);
    step(236);
    check("roll_min", 32'(min), 1);
    check("roll_sec", 32'(sec), 0);
    ss = 1'b1; step(1); ss = 1'b0;
    check("stop_running", 32'(running), 0);

    // loads and full wrap to midnight
    do_load(2'b10, 6'd23);
    do_load(2'b01, 6'd59);
    do_load(2'b00, 6'd59);
    check("load_hrs", 32'(hrs), 23);
    check("load_min", 32'(min), 59);
    check("load_sec", 32'(sec), 59);
    do_load(2'b11, 6'd5);
    check("load_nop_sec", 32'(sec), 59);
    check("load_nop_min", 32'(min), 59);
    ss = 1'b1; step(1); ss = 1'b0;
    step(3);
    check("wrap_pre_sec", 32'(sec), 59);
    step(1);
    check("wrap_hrs", 32'(hrs), 0);
    check("wrap_min", 32'(min), 0);
    check("wrap_sec", 32'(sec), 0);
    do_load(2'b00, 6'd63);
    check("sat_sec", 32'(sec), 59);
    do_load(2'b10, 6'd30);
    check("sat_hrs", 32'(hrs), 23);
    ss = 1'b1; step(1); ss = 1'b0;
    check("stop2_running", 32'(running), 0);

    // field select and dec wrap
    do_load(2'b00, 6'd0);
    pulse(4'b0100);
    check("edit_f1", 32'(edit_field), 1);
    check("edit_norun", 32'(running), 0);
    pulse(4'b0100);
    pulse(4'b0100);
    check("edit_f3", 32'(edit_field), 3);
    pulse(4'b0100);
    check("edit_f1_again", 32'(edit_field), 1);
    pulse(4'b0001);
    check("dec_sec", 32'(sec), 59);
    check("dec_min", 32'(min), 0);
    check("dec_hrs", 32'(hrs), 23);

    // hold-to-repeat on minutes
    pulse(4'b0100);
    check("edit_f2", 32'(edit_field), 2);
    do_load(2'b01, 6'd10);
    inc = 1'b1; step(13); inc = 1'b0;
    check("repeat_min", 32'(min), 14);
    step(1);
    pulse(4'b0010);
    check("repress_min", 32'(min), 15);
    check("repeat_sec", 32'(sec), 59);

    // idle timeout
    do_load(2'b11, 6'd0);
    step(19);
    check("to_early_cnt", 32'(evt_cnt), 0);
    check("to_early_field", 32'(edit_field), 2);
    step(1);
    check("to_evt", 32'(timeout_evt), 1);
    check("to_field", 32'(edit_field), 0);
    check("to_running", 32'(running), 0);
    step(1);
    check("to_evt_low", 32'(timeout_evt), 0);
    check("to_cnt", 32'(evt_cnt), 1);

    // ss and inc together: only ss acts
    pulse(4'b0100);
    {ss, inc} = 2'b11; step(1); {ss, inc} = 2'b00;
    check("prio_running", 32'(running), 1);
    check("prio_field", 32'(edit_field), 0);
    check("prio_sec", 32'(sec), 59);
    step(1);
    ss = 1'b1; step(1); ss = 1'b0;
    step(1);

    // reset mid-repeat, buttons held across reset must not fire
    pulse(4'b0100);
    inc = 1'b1; step(10);
    check("rpt2_sec", 32'(sec), 1);
    check("rpt2_min", 32'(min), 15);
    rst = 1'b0; step(1);
    check("rst2_hrs", 32'(hrs), 0);
    check("rst2_min", 32'(min), 0);
    check("rst2_sec", 32'(sec), 0);
    check("rst2_field", 32'(edit_field), 0);
    check("rst2_running", 32'(running), 0);
    ss = 1'b1; step(1);
    rst = 1'b1; step(4);
    check("held_ss_norun", 32'(running), 0);
    check("held_sec", 32'(sec), 0);
    ss = 1'b0; inc = 1'b0; step(1);
    pulse(4'b1000);
    check("repress_ss", 32'(running), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
